conv_window_ctrl: RTL
=====================

// Module: conv_window_ctrl
// PURPOSE
//  Sequencer for the 3x3 convolution line-buffer BRAM (1 write port, KERNEL*KERNEL read ports).
//  Accepts a raster pixel stream and generates the BRAM write address/enable.
//  Generates the KERNEL*KERNEL read addresses of the current window.
//  Flags when the BRAM read data holds a valid window for the DSP cascade.
//  Sits between the pixel source and the bram instance; one frame per i_start.
// PARAMETERS
//  ADDR_WIDTH  6   BRAM address width; must be >= clog2(RAM_DEPTH)
//  RAM_WIDTH   8   pixel width
//  KERNEL      3   window side; read ports = KERNEL*KERNEL
//  IMG_WIDTH   9   pixels per row
//  IMG_HEIGHT  9   rows per frame
//  RAM_DEPTH   21  circular buffer depth; must be >= (KERNEL-1)*IMG_WIDTH+KERNEL
// PORTS
//  i_clk        in   1                          clock
//  i_rst        in   1                          synchronous active-high reset
//  i_start      in   1                          start a frame; honoured only in IDLE
//  i_valid      in   1                          input pixel valid
//  o_ready      out  1                          controller accepts a pixel
//  i_data       in   RAM_WIDTH                  input pixel
//  o_wr_en      out  1                          BRAM write enable
//  o_w_addrs    out  ADDR_WIDTH                 BRAM write address
//  o_wr_data    out  RAM_WIDTH                  BRAM write data
//  o_r_addrs    out  ADDR_WIDTH*KERNEL*KERNEL   BRAM read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//  o_win_valid  out  1                          BRAM o_data holds a valid window this cycle
//  o_win_row    out  8                          output row of the current window, 0..IMG_HEIGHT-KERNEL
//  o_win_col    out  8                          output column of the current window, 0..IMG_WIDTH-KERNEL
//  o_done       out  1                          one-cycle pulse when the frame is complete
// BEHAVIOUR
//  - Accept: acc = i_valid & o_ready. o_wr_en = acc (combinational). o_wr_data = i_data. o_w_addrs = wp (register).
//  - Pointer wrap: wp increments on acc and wraps from RAM_DEPTH-1 to 0.
//  - Counters: col and row track the accepted pixel. col wraps at IMG_WIDTH-1, which increments row.
//  - FSM states:
//    - IDLE: o_ready=0. i_start moves to FILL.
//    - FILL: o_ready=1. Acceptance of the pixel at row==KERNEL-1, col==KERNEL-1 moves to RUN.
//    - RUN: o_ready=1. Acceptance of the last pixel (row IMG_HEIGHT-1, col IMG_WIDTH-1) moves to DRAIN.
//    - DRAIN: o_ready=0. Stays 2 cycles, then moves to DONE.
//    - DONE: o_done=1 for 1 cycle, then IDLE. Counters and wp return to 0.
//  - Window issue: acc at cycle t with row>=KERNEL-1 and col>=KERNEL-1 is a window hit.
//    - At t+1, o_r_addrs is registered.
//    - Port k = r*KERNEL+c (r,c in 0..KERNEL-1, port 0 = top-left/oldest, last port = newest).
//    - Port k address = (wa - off) mod RAM_DEPTH, with wa = write address used at t and off = (KERNEL-1-r)*IMG_WIDTH + (KERNEL-1-c).
//    - Modulo: wa>=off ? wa-off : wa+RAM_DEPTH-off. No '%' operator.
//    - Issuing at t+1 avoids same-cycle read-during-write; the BRAM returns the freshly written pixel.
//  - Window valid: o_win_valid=1 at t+2 (BRAM 1-cycle read latency), aligned with BRAM o_data.
//    o_win_row/o_win_col are registered alongside it.
//  - Row edges: pixels with col<KERNEL-1 or row<KERNEL-1 are written but produce no window.
//  - Read addresses: o_r_addrs holds its last value when no window is issued.
//  - Window count: IMG_HEIGHT-KERNEL+1 rows x IMG_WIDTH-KERNEL+1 cols per frame.
//  - Ordering: the last o_win_valid precedes o_done by exactly 1 cycle.
//  - Simultaneous i_start & i_valid in IDLE: start honoured, pixel NOT accepted (o_ready=0).
//  - i_start outside IDLE: ignored.
//  - i_valid low: counters, wp and FSM hold. Gaps in i_valid never produce spurious o_win_valid.
//  - Reset mid-frame (any state): next cycle is IDLE.
//    - Cleared: wp, row, col, o_r_addrs, o_win_row, o_win_col = 0.
//    - Low: o_win_valid, o_done, o_wr_en (o_ready=0).
//    - In-flight windows are dropped. BRAM contents are not cleared; stale data is never flagged valid.
// TESTING
//  1. Defaults, i_start then 81 back-to-back pixels (1..81):
//     - First o_win_valid 2 cycles after pixel 21 (wp=20), with ports 0..8 = {0,1,2,9,10,11,18,19,20}.
//     - 49 windows in total; o_done 1 cycle after the last window.
//  2. Wrap check, pixel 22 (written at addr 0, window row0 col1): ports 0..8 = {1,2,3,10,11,12,19,20,0}.
//  3. Row edge: pixels at col 0/1 of rows 2..8 produce no o_win_valid; window count per row = 7.
//  4. i_valid toggling 1-0-1 across the frame: same 49 windows with same addresses, only delayed.
//     No o_win_valid during gaps.
//  5. i_rst asserted in RUN at pixel 40: next cycle o_ready=0, o_win_valid=0, wp=0.
//     A new i_start and 81 pixels give scenario-1 results.
//  6. i_start with i_valid=1 in IDLE: first accepted pixel is the one presented the cycle after.
//     i_start pulsed mid-RUN has no effect.

Source files
------------

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: write/read address sequencer for a KERNELxKERNEL
// convolution line buffer held in a circular BRAM. Accepts one raster frame
// per i_start, writes every pixel and issues the read addresses of each
// complete window one cycle after its newest pixel was written.
module conv_window_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int RAM_WIDTH  = 8,
  parameter int KERNEL     = 3,
  parameter int IMG_WIDTH  = 9,
  parameter int IMG_HEIGHT = 9,
  parameter int RAM_DEPTH  = 21
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_start,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic [RAM_WIDTH-1:0]                 i_data,
  output logic                                 o_wr_en,
  output logic [ADDR_WIDTH-1:0]                o_w_addrs,
  output logic [RAM_WIDTH-1:0]                 o_wr_data,
  output logic [ADDR_WIDTH*KERNEL*KERNEL-1:0]  o_r_addrs,
  output logic                                 o_win_valid,
  output logic [7:0]                           o_win_row,
  output logic [7:0]                           o_win_col,
  output logic                                 o_done
);

  localparam int                    NPORT    = KERNEL * KERNEL;
  localparam logic [ADDR_WIDTH-1:0] WP_LAST  = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_X  = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [7:0]            K_M1     = 8'(KERNEL - 1);
  localparam logic [7:0]            COL_LAST = 8'(IMG_WIDTH - 1);
  localparam logic [7:0]            ROW_LAST = 8'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                          state;
  state_t                          state_next;
  logic                            drain_cnt;
  logic [ADDR_WIDTH-1:0]           wp;
  logic [7:0]                      col;
  logic [7:0]                      row;
  logic                            acc;
  logic                            hit;
  logic                            win_pend;
  logic [7:0]                      pend_row;
  logic [7:0]                      pend_col;
  logic [ADDR_WIDTH*NPORT-1:0]     r_addrs_next;

  // Distance (in pixels) from the newest window pixel back to tap (r,c).
  function automatic logic [ADDR_WIDTH-1:0] tap_offset(input int r, input int c);
    return ADDR_WIDTH'((KERNEL - 1 - r) * IMG_WIDTH + (KERNEL - 1 - c));
  endfunction

  // Circular-buffer subtraction without a modulo operator.
  function automatic logic [ADDR_WIDTH-1:0] wrap_sub(input logic [ADDR_WIDTH-1:0] wa,
                                                     input logic [ADDR_WIDTH-1:0] off);
    logic [ADDR_WIDTH:0] ext;
    if (wa >= off) begin
      ext = {1'b0, wa} - {1'b0, off};
    end else begin
      ext = {1'b0, wa} + DEPTH_X - {1'b0, off};
    end
    return ext[ADDR_WIDTH-1:0];
  endfunction

  assign acc       = i_valid & o_ready;
  assign hit       = acc && (row >= K_M1) && (col >= K_M1);
  assign o_wr_en   = acc;
  assign o_wr_data = i_data;
  assign o_w_addrs = wp;

  // Next-state decode and the ready handshake for each phase of the frame.
  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b0;
        if (i_start) state_next = FILL;
        else         state_next = IDLE;
      end
      FILL: begin
        o_ready = 1'b1;
        if (i_valid && (row == K_M1) && (col == K_M1)) state_next = RUN;
        else                                           state_next = FILL;
      end
      RUN: begin
        o_ready = 1'b1;
        if (i_valid && (row == ROW_LAST) && (col == COL_LAST)) state_next = DRAIN;
        else                                                   state_next = RUN;
      end
      DRAIN: begin
        o_ready = 1'b0;
        if (drain_cnt) state_next = DONE;
        else           state_next = DRAIN;
      end
      DONE: begin
        o_ready    = 1'b0;
        state_next = IDLE;
      end
      default: begin
        o_ready    = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // State register, two-cycle drain timer and the registered done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_next;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      o_done    <= (state_next == DONE);
    end
  end

  // Write pointer and raster position of the next pixel; cleared at frame end.
  always_ff @(posedge i_clk) begin
    if (i_rst || (state == DONE)) begin
      wp  <= {ADDR_WIDTH{1'b0}};
      col <= 8'd0;
      row <= 8'd0;
    end else if (acc) begin
      wp <= (wp == WP_LAST) ? {ADDR_WIDTH{1'b0}} : wp + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      if (col == COL_LAST) begin
        col <= 8'd0;
        row <= row + 8'd1;
      end else begin
        col <= col + 8'd1;
      end
    end else begin
      wp  <= wp;
      col <= col;
      row <= row;
    end
  end

  // Read address of every tap, port 0 = oldest (top-left), last = newest.
  always_comb begin
    r_addrs_next = {(ADDR_WIDTH*NPORT){1'b0}};
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL; c++) begin
        r_addrs_next[(r*KERNEL+c)*ADDR_WIDTH +: ADDR_WIDTH] = wrap_sub(wp, tap_offset(r, c));
      end
    end
  end

  // Window pipeline: addresses one cycle after the write, valid one cycle later
  // to match the BRAM read latency. Reset drops anything in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      win_pend    <= 1'b0;
      pend_row    <= 8'd0;
      pend_col    <= 8'd0;
      o_r_addrs   <= {(ADDR_WIDTH*NPORT){1'b0}};
      o_win_valid <= 1'b0;
      o_win_row   <= 8'd0;
      o_win_col   <= 8'd0;
    end else begin
      win_pend    <= hit;
      o_win_valid <= win_pend;
      if (hit) begin
        o_r_addrs <= r_addrs_next;
        pend_row  <= row - K_M1;
        pend_col  <= col - K_M1;
      end else begin
        o_r_addrs <= o_r_addrs;
        pend_row  <= pend_row;
        pend_col  <= pend_col;
      end
      if (win_pend) begin
        o_win_row <= pend_row;
        o_win_col <= pend_col;
      end else begin
        o_win_row <= o_win_row;
        o_win_col <= o_win_col;
      end
    end
  end

endmodule
